// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes
// driven by the decoder, plus a small alignment helper.
package ifetch_pkg;

    localparam logic [2:0] PC_NEXT_SEL_STALL       = 3'd0;
    localparam logic [2:0] PC_NEXT_SEL_NEXT        = 3'd1;
    localparam logic [2:0] PC_NEXT_SEL_PC_IMM      = 3'd2;
    localparam logic [2:0] PC_NEXT_SEL_RS1_IMM     = 3'd3;
    localparam logic [2:0] PC_NEXT_SEL_COND_PC_IMM = 3'd4;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_pc_next_calc.sv
// Combinational next-PC former: selects sequential, JAL, JALR or branch
// target from the decoder's select code and flags unaligned results.
module pc_next_calc
    import ifetch_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [20:0] off,
    input  logic [2:0]  isize,
    input  logic [31:0] rs1,
    input  logic        alu_taken,
    input  logic [31:0] pc,
    output logic [31:0] target,
    output logic        stall,
    output logic        misaligned
);

    logic signed [31:0] off_j;
    logic signed [31:0] off_i;
    logic signed [31:0] off_b;
    logic [31:0] seq_pc;
    logic [31:0] jal_pc;
    logic [31:0] jalr_pc;
    logic [31:0] br_pc;

    assign off_j   = {{11{off[20]}}, off[20:0]};
    assign off_i   = {{20{off[11]}}, off[11:0]};
    assign off_b   = {{19{off[12]}}, off[12:0]};

    // All sums wrap modulo 2^32; there is no overflow reporting.
    assign seq_pc  = pc + {29'd0, isize};
    assign jal_pc  = pc + off_j;
    assign jalr_pc = (rs1 + off_i) & ~32'h1;
    assign br_pc   = pc + off_b;

    always_comb begin
        target = pc;
        stall  = 1'b0;
        case (sel)
            PC_NEXT_SEL_NEXT:        target = seq_pc;
            PC_NEXT_SEL_PC_IMM:      target = jal_pc;
            PC_NEXT_SEL_RS1_IMM:     target = jalr_pc;
            PC_NEXT_SEL_COND_PC_IMM: target = alu_taken ? br_pc : seq_pc;
            default:                 stall  = 1'b1;
        endcase
    end

    assign misaligned = is_misaligned(target[1:0]);

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over a
// req/gnt/rvalid port and hands it to the decoder until it asks to advance.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  pc_next_sel_i,
    input  logic [31:0] pc_next_off_i,
    input  logic [2:0]  pc_isize_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] alu_res_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_data_o,
    output logic        instr_valid_o,
    output logic        misalign_o
);

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_VALID = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] target;
    logic        stall;
    logic        misaligned;

    // Only the immediate bits the target formats use, and only the branch flag.
    logic [10:0] unused_off;
    logic [30:0] unused_alu;
    assign unused_off = pc_next_off_i[31:21];
    assign unused_alu = alu_res_i[31:1];

    pc_next_calc u_pc_next_calc (
        .sel        (pc_next_sel_i),
        .off        (pc_next_off_i[20:0]),
        .isize      (pc_isize_i),
        .rs1        (rs1_data_i),
        .alu_taken  (alu_res_i[0]),
        .pc         (pc),
        .target     (target),
        .stall      (stall),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = ST_REQ;
            ST_REQ:   if (imem_gnt_i) state_next = ST_WAIT;
            ST_WAIT:  if (imem_rvalid_i) state_next = ST_VALID;
            ST_VALID: if (!stall) state_next = misaligned ? ST_HALT : ST_REQ;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_RESET;
        endcase
    end

    // The PC takes the target even when it is misaligned, so the faulting
    // address stays visible on pc_o while halted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc <= RESET_PC;
        end else if (state == ST_VALID && !stall) begin
            pc <= target;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == ST_WAIT && imem_rvalid_i) begin
            instr <= imem_rdata_i;
        end
    end

    always_comb begin
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        misalign_o    = 1'b0;
        pc_data_o     = NOP_INSTR;
        case (state)
            ST_REQ:   imem_req_o = 1'b1;
            ST_VALID: begin
                instr_valid_o = 1'b1;
                pc_data_o     = instr;
            end
            ST_HALT:  misalign_o = 1'b1;
            default:  ;
        endcase
    end

    assign pc_o        = pc;
    assign imem_addr_o = pc;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a memory responder and a decoder driver feed the DUT
// while a monitor scores fetched instructions against a reference PC model.
`timescale 1ns/1ps
module tb_ifetch;
    import ifetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sel = PC_NEXT_SEL_STALL;
    logic [31:0] off = '0;
    logic [2:0]  isize = 3'd4;
    logic [31:0] rs1 = '0;
    logic [31:0] alu = '0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_data_o;
    logic        instr_valid_o;
    logic        misalign_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int gdly = 0;
    int rextra = 0;
    bit rand_mode = 0;
    logic [31:0] pc_q[$];
    logic [31:0] data_q[$];
    logic [31:0] model_pc;
    logic [31:0] cur_data = '0;

    ifetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_next_sel_i (sel),
        .pc_next_off_i (off),
        .pc_isize_i    (isize),
        .rs1_data_i    (rs1),
        .alu_res_i     (alu),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .pc_o          (pc_o),
        .pc_data_o     (pc_data_o),
        .instr_valid_o (instr_valid_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction memory: grants after a delay, returns random data later.
    initial begin : responder
        int phase, cnt, gr, rr;
        gnt = 0; rvalid = 0; rdata = '0;
        phase = 0; cnt = 0; gr = 0; rr = 0;
        forever begin
            @(posedge clk); #1;
            gnt = 0; rvalid = 0;
            if (rst) begin
                phase = 0; cnt = 0;
            end else if (phase == 0) begin
                if (imem_req_o) begin
                    if (pc_q.size() == 0) chk("req_unexpected", 32'(imem_req_o), 32'd0);
                    else chk("req_addr", imem_addr_o, pc_q[0]);
                    if (cnt >= (rand_mode ? gr : gdly)) begin
                        gnt = 1; phase = 1; cnt = 0; rr = $urandom_range(2, 0);
                    end else begin
                        cnt++;
                    end
                end
                if (!gnt && rand_mode && $urandom_range(3, 0) == 0) begin
                    rvalid = 1; rdata = $urandom;
                end
            end else begin
                chk("no_dup_req", 32'(imem_req_o), 32'd0);
                if (cnt >= (rand_mode ? rr : rextra)) begin
                    rvalid = 1; rdata = $urandom;
                    data_q.push_back(rdata);
                    phase = 0; cnt = 0; gr = $urandom_range(3, 0);
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Scores each newly presented instruction; idle cycles must show the NOP.
    initial begin : monitor
        logic pv;
        logic [31:0] pe, de;
        pv = 0;
        forever begin
            @(negedge clk);
            if (!instr_valid_o) chk("nop_when_idle", pc_data_o, NOP);
            if (!rst && instr_valid_o && !pv) begin
                if (pc_q.size() == 0 || data_q.size() == 0) begin
                    chk("valid_unexpected", 32'd1, 32'd0);
                end else begin
                    pe = pc_q.pop_front();
                    de = data_q.pop_front();
                    chk("instr_pc", pc_o, pe);
                    chk("instr_data", pc_data_o, de);
                    cur_data = de;
                end
            end
            pv = instr_valid_o;
        end
    end

    task automatic do_reset();
        rst = 1;
        sel = PC_NEXT_SEL_STALL;
        pc_q.delete();
        data_q.delete();
        model_pc = RESET_PC;
        pc_q.push_back(RESET_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_data", pc_data_o, NOP);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        @(posedge clk); #2;
        rst = 0;
    endtask

    // Waits for a presented instruction, then drives one decoder decision.
    task automatic issue(input logic [2:0] s, input logic [31:0] o, input logic [31:0] r, input logic a);
        int n;
        logic [31:0] t;
        logic [31:0] step;
        bit adv;
        n = 0;
        while (!instr_valid_o && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (!instr_valid_o) begin
            chk("valid_timeout", 32'd0, 32'd1);
            return;
        end
        issue_cyc = cyc;
        sel = s; off = o; rs1 = r; alu = {31'($urandom), a};
        step = {29'd0, isize};
        adv = 1;
        case (s)
            PC_NEXT_SEL_NEXT:        t = model_pc + step;
            PC_NEXT_SEL_PC_IMM:      t = model_pc + 32'($signed(o[20:0]));
            PC_NEXT_SEL_RS1_IMM:     t = (r + 32'($signed(o[11:0]))) & ~32'h1;
            PC_NEXT_SEL_COND_PC_IMM: t = a ? model_pc + 32'($signed(o[12:0])) : model_pc + step;
            default: begin adv = 0; t = model_pc; end
        endcase
        if (adv) begin
            model_pc = t;
            if (t[1:0] == 2'b00) pc_q.push_back(t);
        end
        @(posedge clk); #2;
        sel = PC_NEXT_SEL_STALL;
        off = $urandom;
        if (!adv) begin
            chk("stall_valid", 32'(instr_valid_o), 32'd1);
            chk("stall_pc", pc_o, model_pc);
            chk("stall_data", pc_data_o, cur_data);
            chk("stall_req", 32'(imem_req_o), 32'd0);
        end
    endtask

    task automatic chk_halted(input logic [31:0] exp_pc);
        chk("halt_pc", pc_o, exp_pc);
        repeat (3) begin
            @(negedge clk);
            chk("halt_misalign", 32'(misalign_o), 32'd1);
            chk("halt_req", 32'(imem_req_o), 32'd0);
            chk("halt_valid", 32'(instr_valid_o), 32'd0);
        end
        @(posedge clk); #2;
    endtask

    initial begin : main
        int prev;
        logic [2:0] s;
        @(posedge clk); #2;

        // Back-to-back sequential fetch with the fastest memory.
        gdly = 0; rextra = 0; rand_mode = 0;
        do_reset();
        issue(PC_NEXT_SEL_NEXT, 32'd0, 32'd0, 1'b0);
        prev = issue_cyc;
        repeat (2) begin
            issue(PC_NEXT_SEL_NEXT, 32'd0, 32'd0, 1'b0);
            chk("seq_spacing", 32'(issue_cyc - prev), 32'd3);
            prev = issue_cyc;
        end

        // Slow grant: address must hold and only one request may be issued.
        gdly = 3; rextra = 1;
        repeat (2) issue(PC_NEXT_SEL_NEXT, 32'd0, 32'd0, 1'b0);

        // Load stall for two cycles, then advance.
        gdly = 0; rextra = 0;
        issue(PC_NEXT_SEL_STALL, 32'd0, 32'd0, 1'b0);
        issue(PC_NEXT_SEL_STALL, 32'd0, 32'd0, 1'b0);
        issue(PC_NEXT_SEL_NEXT, 32'd0, 32'd0, 1'b0);

        // Branches around 0x100.
        issue(PC_NEXT_SEL_PC_IMM, 32'h100 - model_pc, 32'd0, 1'b0);
        issue(PC_NEXT_SEL_COND_PC_IMM, 32'h1FF8, 32'd0, 1'b1);
        chk("beq_taken", pc_o, 32'h0000_00F8);
        issue(PC_NEXT_SEL_PC_IMM, 32'h100 - model_pc, 32'd0, 1'b0);
        issue(PC_NEXT_SEL_COND_PC_IMM, 32'h1FF8, 32'd0, 1'b0);
        chk("beq_not_taken", pc_o, 32'h0000_0104);

        // JAL wrap below zero, then JALR that clears bit 0 but lands unaligned.
        issue(PC_NEXT_SEL_PC_IMM, 32'h0 - model_pc, 32'd0, 1'b0);
        issue(PC_NEXT_SEL_PC_IMM, 32'h0010_0000, 32'd0, 1'b0);
        chk("jal_wrap", pc_o, 32'hFFF0_0000);
        issue(PC_NEXT_SEL_RS1_IMM, 32'h0000_0FFF, 32'h0000_0203, 1'b0);
        chk_halted(32'h0000_0202);

        // Misaligned JALR from a fresh start.
        do_reset();
        issue(PC_NEXT_SEL_RS1_IMM, 32'd0, 32'h0000_0102, 1'b0);
        chk_halted(32'h0000_0102);

        // Reset while waiting for read data.
        do_reset();
        rextra = 5;
        issue(PC_NEXT_SEL_NEXT, 32'd0, 32'd0, 1'b0);
        repeat (2) begin @(posedge clk); #2; end
        chk("wait_pc", pc_o, 32'h0000_0004);
        chk("wait_valid", 32'(instr_valid_o), 32'd0);
        do_reset();

        // Randomised traffic with aligned targets and random memory timing.
        rand_mode = 1;
        for (int i = 0; i < 150; i++) begin
            s = 3'($urandom_range(7, 0));
            case (s)
                PC_NEXT_SEL_PC_IMM:      issue(s, $urandom & 32'h001F_FFFC, 32'd0, 1'b0);
                PC_NEXT_SEL_RS1_IMM:     issue(s, $urandom & 32'h0000_0FFC, $urandom & ~32'h3, 1'b0);
                PC_NEXT_SEL_COND_PC_IMM: issue(s, $urandom & 32'h0000_1FFC, 32'd0, 1'($urandom));
                default:                 issue(s, $urandom, $urandom, 1'($urandom));
            endcase
        end
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
